// File: rtl/simd_act_pkg.sv
// Shared definitions for the 2-lane tanh/sigmoid activation datapath and its
// downstream lane serializer: sample width, lane count, Q5.11 constants,
// the packed result-pair type and the serializer output-stage state encoding.
package simd_act_pkg;

  localparam int DATA_W = 16;
  localparam int LANES  = 2;

  // Q5.11: 1.0 and the activation output saturation limits.
  localparam logic signed [DATA_W-1:0] Q_ONE   = 16'sd2048;
  localparam logic signed [DATA_W-1:0] SAT_POS = 16'sd2038;
  localparam logic signed [DATA_W-1:0] SAT_NEG = -16'sd2038;

  // One result pair as produced by the activation pipeline, lane 0 in the LSBs.
  typedef struct packed {
    logic signed [DATA_W-1:0] lane1;
    logic signed [DATA_W-1:0] lane0;
  } pair_t;

  // Serializer output stage: empty, presenting lane 0, presenting lane 1.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LANE0 = 2'd1,
    ST_LANE1 = 2'd2
  } ser_state_t;

endpackage

// File: rtl/simd_pair_fifo.sv
// DEPTH-entry FIFO of packed result pairs with push/pop and an occupancy
// counter. full/empty are decoded from the level; pointers wrap naturally.
// A push on a full FIFO is legal only together with a pop on the same edge.
module simd_pair_fifo
  import simd_act_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [LANES*DATA_W-1:0]   i_wdata,
  input  logic                      i_pop,
  output logic [LANES*DATA_W-1:0]   o_rdata,
  output logic [$clog2(DEPTH):0]    o_level,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [LANES*DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [AW:0]             r_level;

  // Pair storage; payload only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/simd_lane_serializer.sv
// Captures activation result pairs (lane 0, lane 1) on a non-backpressured
// valid strobe into a pair FIFO, then serializes them lane 0 first onto a
// ready/valid stream. Pairs arriving with no room are dropped whole and flagged.
// Build option: define SIMD_SERIALIZER_DROP_COUNT_EN for a saturating 16-bit
// dropped-pair counter; otherwise drop_count is constant zero.
module simd_lane_serializer
  import simd_act_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] y0_in,
  input  logic signed [DATA_W-1:0] y1_in,
  input  logic                     valid_in,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_lane,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  ser_state_t                r_state;
  ser_state_t                w_next;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_drop;
  logic                      w_hs;
  logic                      w_full;
  logic                      w_empty;
  logic [LANES*DATA_W-1:0]   w_rdata;
  logic signed [DATA_W-1:0]  r_out_data;
  logic signed [DATA_W-1:0]  r_y1;
  logic                      r_overflow;

  assign w_hs   = out_valid & out_ready;
  // A pop frees a slot on the same edge, so a full FIFO still accepts then.
  assign w_push = valid_in & (~w_full | w_pop);
  assign w_drop = valid_in & w_full & ~w_pop;

  simd_pair_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({y1_in, y0_in}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Output-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_next;
  end

  // Next state and FIFO pop: load a pair when idle or right after lane 1 leaves.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ST_LANE0;
        end
      end
      ST_LANE0: begin
        if (w_hs) w_next = ST_LANE1;
      end
      ST_LANE1: begin
        if (w_hs) begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = ST_LANE0;
          end else begin
            w_next = ST_EMPTY;
          end
        end
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  // Output data register: lane 0 on load, lane 1 after the lane 0 handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_y1       <= '0;
    end else if (w_pop) begin
      r_out_data <= w_rdata[DATA_W-1:0];
      r_y1       <= w_rdata[LANES*DATA_W-1:DATA_W];
    end else if (r_state == ST_LANE0 && w_hs) begin
      r_out_data <= r_y1;
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

`ifdef SIMD_SERIALIZER_DROP_COUNT_EN
  logic [15:0] r_drop_count;

  // Saturating dropped-pair counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_drop_count <= '0;
    else if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = '0;
`endif

  assign out_data  = r_out_data;
  assign out_lane  = (r_state == ST_LANE1);
  assign out_valid = (r_state != ST_EMPTY);
  assign overflow  = r_overflow;

endmodule

// File: doc/simd_lane_serializer.md
# simd_lane_serializer

Downstream companion of the 2-lane tanh/sigmoid activation pipeline. Captures each Q5.11 result pair (lane 0, lane 1) on the pipeline's valid strobe, which has no backpressure, and buffers it in a pair FIFO. It then serializes the pairs onto a single-lane ready/valid stream, lane 0 first. Overflow is flagged rather than stalling upstream.

## Interface
- DATA_W, 16, sample width (Q5.11 signed)
- DEPTH, 8, FIFO depth in pairs; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- y0_in  in  DATA_W  lane 0 sample from activation stage
- y1_in  in  DATA_W  lane 1 sample from activation stage
- valid_in  in  1  pair valid; single-cycle strobe, no ready returned
- out_data  out  DATA_W  serialized sample
- out_lane  out  1  0 = out_data came from lane 0, 1 = from lane 1
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- fifo_level  out  $clog2(DEPTH)+1  pairs held in FIFO, excluding the output stage
- overflow  out  1  sticky; set when a pair is dropped
- drop_count  out  16  saturating count of dropped pairs; see Configuration

## Operation
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Storage: pair FIFO of DEPTH entries plus a one-pair output stage.
- Output FSM states:
  - EMPTY: out_valid = 0.
  - LANE0: out_data = stored y0, out_lane = 0.
  - LANE1: out_data = stored y1, out_lane = 1.
- FSM transitions:
  - EMPTY → LANE0 when the FIFO is non-empty. The pair is popped into the output stage.
  - LANE0 → LANE1 on handshake (out_valid & out_ready).
  - LANE1 on handshake: goes to LANE0 with the next pair popped on the same edge if the FIFO is non-empty, otherwise to EMPTY.
  - No handshake: state and out_data hold.
- Write rule: valid_in is accepted if the FIFO is not full, or if a pop occurs on the same edge.
- Drop rule: when valid_in arrives and the write rule fails, the pair is dropped whole, never split. overflow is set.
- overflow clears only on reset.
- Effective capacity: DEPTH+1 pairs.
- Data passes through unmodified. No arithmetic or saturation is applied.
- Pointers are $clog2(DEPTH) bits and wrap naturally. full/empty are derived from fifo_level.
- Simultaneous push and pop: fifo_level is unchanged.
- Reset mid-operation: FIFO contents are discarded immediately, including any partially sent pair. The FSM returns to EMPTY.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_lane = 0, fifo_level = 0, overflow = 0, drop_count = 0. Pointers and FSM are zero / EMPTY.
- Latency: pair sampled at edge E with the output stage EMPTY → out_valid = 1 with y0 after edge E+1. y1 follows one cycle after the lane 0 handshake.
- Throughput: 1 sample/cycle with out_ready held high. Back-to-back pairs have no bubble.
- Upstream can sustain 1 pair per 2 cycles indefinitely. Faster bursts consume buffer space.
- out_valid, out_data and out_lane are registered. Once out_valid is asserted, out_data and out_lane stay stable until the handshake. out_valid never deasserts without a handshake.
- out_ready may toggle freely. It is never combinationally required by out_valid.

## Configuration
- SIMD_SERIALIZER_DROP_COUNT_EN defined: drop_count increments by 1 per dropped pair and saturates at 0xFFFF. It clears only on reset.
- Macro undefined: drop_count is tied to 0 and no counter logic is synthesized. overflow behaves identically in both builds.

## Structure
- Shared package simd_act_pkg holds:
  - DATA_W and LANES = 2.
  - The Q5.11 ONE constant, 2048.
  - The saturation constants ±2038.
  - A packed pair typedef {lane1, lane0}.
- The activation stages and this block share simd_act_pkg.
- One sub-module, simd_pair_fifo, holds the DEPTH-entry pair storage with push/pop/level logic. The serializer FSM, output stage and overflow logic live in the top.

## Test plan
- Reset: assert rst_n = 0 mid-stream with 3 pairs buffered → all outputs read 0 while rst_n is low. After release, out_valid stays 0 until new input arrives.
- Single pair: y0 = 0x07F6, y1 = 0xF80A, out_ready = 1 → after E+1, out_data = 0x07F6 with out_lane = 0, then 0xF80A with out_lane = 1, then out_valid = 0.
- Backpressure: out_ready = 0 for 3 cycles while in LANE0 → out_data and out_lane are stable and out_valid stays high. Raising out_ready then delivers lane 0 followed by lane 1.
- Overflow: DEPTH = 8, out_ready = 0, 10 consecutive pairs → 9 accepted, fifo_level = 8, overflow = 1, drop_count = 1 with the macro defined. Draining yields 18 words in order.
- Full with simultaneous pop: FIFO full, LANE1 handshake on the same edge as valid_in → the pair is accepted, fifo_level stays 8, overflow stays 0.
- Pointer wrap-around: 3·DEPTH pairs at 1 pair per 2 cycles, out_ready = 1 → an ordered, lossless stream, fifo_level ≤ 1, overflow = 0.
